// File: rtl/prog_sequencer.sv
// Program sequencer: fetches words from a synchronous ROM, issues them to a multicycle
// processor with a one-cycle Run pulse, and supports operand refetch, single-step and wrap/halt.
module prog_sequencer #(
  parameter int unsigned N    = 9,
  parameter int unsigned A    = 5,
  parameter int unsigned LAST = 2**A - 1,
  parameter int unsigned C    = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         step_i,
  input  logic         mode_i,
  input  logic         wrap_i,
  input  logic         done_i,
  input  logic         adv_i,
  input  logic [N-1:0] rom_data_i,
  output logic [A-1:0] rom_addr_o,
  output logic [N-1:0] din_o,
  output logic         run_o,
  output logic         halted_o,
  output logic         overrun_o,
  output logic [C-1:0] count_o,
  output logic [2:0]   state_o
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch1 = 3'd1;
  localparam logic [2:0] StFetch2 = 3'd2;
  localparam logic [2:0] StIssue  = 3'd3;
  localparam logic [2:0] StExec   = 3'd4;
  localparam logic [2:0] StPause  = 3'd5;
  localparam logic [2:0] StHalt   = 3'd6;

  localparam logic [A-1:0] LastAddr = A'(LAST);

  logic [2:0]   state_q, state_d;
  logic [A-1:0] addr_q, addr_d;
  logic [N-1:0] din_q, din_d;
  logic [C-1:0] count_q, count_d;
  logic         overrun_q, overrun_d;
  logic         run_q;
  logic [1:0]   refetch_q, refetch_d;
  logic         start_prev_q, step_prev_q;

  logic start_edge, step_edge, at_last;

  assign start_edge = start_i & ~start_prev_q;
  assign step_edge  = step_i & ~step_prev_q;
  assign at_last    = (addr_q == LastAddr);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    din_d     = din_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    refetch_d = 2'b00;
    case (state_q)
      StIdle, StHalt: begin
        if (start_edge) begin
          state_d   = StFetch1;
          addr_d    = '0;
          count_d   = '0;
          overrun_d = 1'b0;
        end
      end
      StFetch1: state_d = StFetch2;
      StFetch2: begin
        din_d   = rom_data_i;
        state_d = StIssue;
      end
      StIssue: state_d = StExec;
      StExec: begin
        // refetch_q[1]: ROM output now holds the word at the address advanced two cycles ago
        if (refetch_q[1]) begin
          din_d = rom_data_i;
        end
        if (done_i) begin
          count_d = count_q + C'(1);
          if (at_last && !wrap_i) begin
            state_d = StHalt;
          end else begin
            addr_d  = at_last ? '0 : addr_q + A'(1);
            state_d = mode_i ? StPause : StFetch1;
          end
        end else begin
          refetch_d[1] = refetch_q[0];
          if (adv_i) begin
            if (at_last && !wrap_i) begin
              overrun_d = 1'b1;
            end else begin
              addr_d       = at_last ? '0 : addr_q + A'(1);
              refetch_d[0] = 1'b1;
            end
          end
        end
      end
      StPause: begin
        if (step_edge || !mode_i) begin
          state_d = StFetch1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      din_q        <= '0;
      count_q      <= '0;
      overrun_q    <= 1'b0;
      run_q        <= 1'b0;
      refetch_q    <= 2'b00;
      start_prev_q <= 1'b1;
      step_prev_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      count_q      <= count_d;
      overrun_q    <= overrun_d;
      run_q        <= (state_q == StIssue);
      refetch_q    <= refetch_d;
      start_prev_q <= start_i;
      step_prev_q  <= step_i;
    end
  end

  assign rom_addr_o = addr_q;
  assign din_o      = din_q;
  assign run_o      = run_q;
  assign halted_o   = (state_q == StHalt);
  assign overrun_o  = overrun_q;
  assign count_o    = count_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: ROM model, reactive processor model, and a Run-pulse scoreboard
// fed by a program-counter reference model.
module tb_prog_sequencer;

  localparam int unsigned N    = 9;
  localparam int unsigned A    = 5;
  localparam int unsigned LAST = 3;
  localparam int unsigned C    = 16;

  localparam logic [2:0] SIdle   = 3'd0;
  localparam logic [2:0] SFetch1 = 3'd1;
  localparam logic [2:0] SExec   = 3'd4;
  localparam logic [2:0] SPause  = 3'd5;
  localparam logic [2:0] SHalt   = 3'd6;

  logic         clk = 1'b0;
  logic         rst_n, start, step, mode, wrap, done, adv;
  logic [N-1:0] rom_data;
  logic [A-1:0] rom_addr;
  logic [N-1:0] din;
  logic         run, halted, overrun;
  logic [C-1:0] count;
  logic [2:0]   state;

  logic [N-1:0] rom [2**A];

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  prog_sequencer #(.N(N), .A(A), .LAST(LAST), .C(C)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .step_i     (step),
    .mode_i     (mode),
    .wrap_i     (wrap),
    .done_i     (done),
    .adv_i      (adv),
    .rom_data_i (rom_data),
    .rom_addr_o (rom_addr),
    .din_o      (din),
    .run_o      (run),
    .halted_o   (halted),
    .overrun_o  (overrun),
    .count_o    (count),
    .state_o    (state)
  );

  typedef struct {
    int           addr;
    logic [N-1:0] word;
  } exp_t;

  exp_t         expq[$];
  logic [N-1:0] opq[$];
  int checks = 0;
  int errors = 0;
  int run_cnt = 0;
  int model_pc;
  int base;
  bit run_prev = 1'b0;
  bit proc_adv = 1'b0;
  bit proc_both = 1'b0;
  bit proc_rand = 1'b0;
  int proc_hold = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Reference program counter: -1 means the program halts.
  function automatic int next_pc(input int pc, input bit w);
    if (pc == int'(LAST)) return w ? 0 : -1;
    return pc + 1;
  endfunction

  task automatic expect_instr(input int pc);
    exp_t e;
    e.addr = pc;
    e.word = rom[pc];
    expq.push_back(e);
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (state == s) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: timeout, state %0d, want %0d", name, state, s);
    end
  endtask

  task automatic wait_runs(input int target, input int max, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (run_cnt >= target) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: timeout, runs %0d, want %0d", name, run_cnt, target);
    end
  endtask

  task automatic step_once();
    step = 1'b1;
    repeat (5) @(negedge clk);
    step = 1'b0;
    wait_state(SPause, 60, "pause_after_step");
  endtask

  // Scoreboard monitor: every Run pulse must match the next expected instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (run === 1'b1) begin
        check("run_single_cycle", run_prev, 0);
        check("run_in_exec", state, SExec);
        run_cnt++;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_run: got run at addr %0d, want none", rom_addr);
        end else begin
          e = expq.pop_front();
          check("run_addr", rom_addr, e.addr);
          check("run_din", din, e.word);
        end
      end
      run_prev = run;
    end
  end

  // Processor model reacting to Run.
  initial begin
    logic [N-1:0] w;
    int dly;
    done = 1'b0;
    adv  = 1'b0;
    forever begin
      @(negedge clk);
      if (run === 1'b1) begin
        if (proc_adv) begin
          @(negedge clk);
          adv = 1'b1;
          @(negedge clk);
          adv = 1'b0;
          @(negedge clk);
          @(negedge clk);
          if (opq.size() > 0) begin
            w = opq.pop_front();
            check("operand_din", din, w);
          end
          repeat (proc_hold) @(negedge clk);
          done = 1'b1;
          @(negedge clk);
          done = 1'b0;
        end else begin
          dly = proc_rand ? int'($urandom_range(2, 4)) : 2;
          repeat (dly - 1) @(negedge clk);
          done = 1'b1;
          adv  = proc_both;
          @(negedge clk);
          done = 1'b0;
          adv  = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2**A; i++) rom[i] = N'($urandom);
    rom[0] = 9'h040;
    rom[1] = 9'h1A5;
    rst_n = 1'b0;
    start = 1'b1;
    step  = 1'b0;
    mode  = 1'b0;
    wrap  = 1'b0;

    // Reset values; Start held high through reset must not trigger.
    repeat (2) @(negedge clk);
    check("rst_state", state, SIdle);
    check("rst_addr", rom_addr, 0);
    check("rst_din", din, 0);
    check("rst_run", run, 0);
    check("rst_halted", halted, 0);
    check("rst_overrun", overrun, 0);
    check("rst_count", count, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("start_held_no_trigger", state, SIdle);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Free-run to halt at LAST.
    model_pc = 0;
    while (model_pc >= 0) begin
      expect_instr(model_pc);
      model_pc = next_pc(model_pc, 1'b0);
    end
    base  = run_cnt;
    start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("first_din", din, 9'h040);
    check("first_run_not_yet", run, 0);
    @(negedge clk);
    check("first_run_pulse", run, 1);
    wait_state(SHalt, 100, "halt_reached");
    check("halt_count", count, 4);
    check("halt_addr", rom_addr, LAST);
    check("halt_flag", halted, 1);
    check("halt_runs", run_cnt - base, 4);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Wrap with random processor latency; switch to single-step after the fifth Run.
    wrap      = 1'b1;
    proc_rand = 1'b1;
    model_pc  = 0;
    repeat (5) begin
      expect_instr(model_pc);
      model_pc = next_pc(model_pc, 1'b1);
    end
    base  = run_cnt;
    start = 1'b1;
    wait_runs(base + 5, 200, "wrap_runs");
    mode = 1'b1;
    wait_state(SPause, 40, "wrap_pause");
    check("wrap_halted", halted, 0);
    check("wrap_count", count, 5);
    check("wrap_addr", rom_addr, model_pc);
    proc_rand = 1'b0;
    start     = 1'b0;

    // Single-step: one instruction per Step edge.
    repeat (3) begin
      expect_instr(model_pc);
      model_pc = next_pc(model_pc, 1'b1);
      base = run_cnt;
      step = 1'b1;
      repeat (5) @(negedge clk);
      step = 1'b0;
      repeat (20) @(negedge clk);
      check("step_one_run", run_cnt - base, 1);
      check("step_pause", state, SPause);
      check("step_addr", rom_addr, model_pc);
    end
    check("step_count", count, 8);

    // Operand fetch: instruction at 0 consumes operand word at 1.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    proc_adv = 1'b1;
    expect_instr(0);
    opq.push_back(rom[1]);
    model_pc = next_pc(next_pc(0, 1'b1), 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1;
    wait_state(SPause, 60, "operand_pause");
    check("operand_count", count, 1);
    check("operand_next_addr", rom_addr, model_pc);
    check("operand_consumed", opq.size(), 0);
    proc_adv = 1'b0;
    expect_instr(model_pc);
    model_pc = next_pc(model_pc, 1'b1);
    step_once();
    check("after_operand_addr", rom_addr, model_pc);

    // Adv at LAST with Wrap=0 sets Overrun; Done there halts.
    wrap     = 1'b0;
    proc_adv = 1'b1;
    expect_instr(model_pc);
    step = 1'b1;
    repeat (5) @(negedge clk);
    step = 1'b0;
    wait_state(SHalt, 60, "overrun_halt");
    check("overrun_set", overrun, 1);
    check("overrun_addr", rom_addr, LAST);
    check("overrun_count", count, 3);
    proc_adv = 1'b0;
    start    = 1'b0;
    expect_instr(0);
    model_pc = next_pc(0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("restart_overrun_clr", overrun, 0);
    check("restart_count_clr", count, 0);
    check("restart_state", state, SFetch1);
    wait_state(SPause, 60, "restart_pause");
    check("restart_addr", rom_addr, model_pc);

    // Done and Adv together: only Done takes effect.
    proc_both = 1'b1;
    expect_instr(model_pc);
    model_pc = next_pc(model_pc, 1'b0);
    step_once();
    check("both_addr", rom_addr, model_pc);
    check("both_count", count, 2);
    check("both_overrun", overrun, 0);
    check("both_din", din, rom[1]);
    proc_both = 1'b0;

    // Reset mid-EXEC with an operand refetch in flight.
    proc_adv  = 1'b1;
    proc_hold = 10;
    expect_instr(model_pc);
    base = run_cnt;
    step = 1'b1;
    wait_runs(base + 1, 40, "midexec_run");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_state", state, SIdle);
    check("midrst_addr", rom_addr, 0);
    check("midrst_count", count, 0);
    check("midrst_din", din, 0);
    check("midrst_run", run, 0);
    @(negedge clk);
    step  = 1'b0;
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("midrst_no_run", run_cnt - base, 1);
    check("midrst_idle", state, SIdle);
    check("midrst_din_kept", din, 0);
    proc_adv  = 1'b0;
    proc_hold = 0;

    check("expq_drained", expq.size(), 0);
    check("opq_drained", opq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Parametrised program sequencer between a synchronous single-port program ROM and the multicycle processor. It generates ROM addresses, registers each fetched word onto the processor's DIN bus, and pulses Run. It then waits for Done before advancing. Supports free-run or single-step mode, wrap or halt at end of program, and mid-instruction operand fetch for multi-word instructions.

## Interface
Parameters:
- N, 9, data/instruction word width
- A, 5, ROM address width
- LAST, 2**A-1, address of last program word
- C, 16, width of executed-instruction counter

Ports:
- Clock  in  1  system clock, all state on rising edge
- Resetn  in  1  asynchronous, active-low reset
- Start  in  1  level; rising edge (internally detected) begins program at address 0 from IDLE or HALT
- Step  in  1  level; rising edge releases one instruction in single-step mode
- Mode  in  1  0 = free-run, 1 = single-step
- Wrap  in  1  1 = after LAST continue at 0; 0 = halt after LAST
- Done  in  1  processor instruction-complete pulse
- Adv  in  1  processor request for next word (operand) during execution
- RomData  in  N  ROM output, valid one cycle after RomAddr sampled by ROM
- RomAddr  out  A  ROM address
- DIN  out  N  registered word presented to processor
- Run  out  1  one-cycle start pulse to processor
- Halted  out  1  high in HALT
- Overrun  out  1  sticky: Adv at LAST with Wrap=0
- Count  out  C  instructions completed (Done accepted), wraps modulo 2**C
- State  out  3  current state encoding, for LEDG debug

## Operation
- States: IDLE(0), FETCH1(1), FETCH2(2), ISSUE(3), EXEC(4), PAUSE(5), HALT(6).
- IDLE: RomAddr=0. Start edge -> FETCH1, Count cleared.
- FETCH1: ROM samples RomAddr at the next edge; -> FETCH2.
- FETCH2: DIN <= RomData; -> ISSUE.
- ISSUE: Run=1 for exactly this cycle; -> EXEC.
- EXEC: wait for Done.
  - Adv=1 (and Done=0): RomAddr+1, then operand refetch: two cycles later DIN <= RomData. FSM stays in EXEC. Runs through internal sub-flag, not a state change.
  - Done=1: Count+1. Then:
    - If RomAddr==LAST and Wrap=0 -> HALT.
    - Else RomAddr <= (RomAddr==LAST ? 0 : RomAddr+1).
    - Then: Mode=0 -> FETCH1; Mode=1 -> PAUSE.
  - Done and Adv same cycle: Done wins, Adv ignored.
- PAUSE: Step edge -> FETCH1. Mode changed to 0 while in PAUSE -> FETCH1 on next cycle.
- HALT: Halted=1, DIN holds last word. Start edge -> RomAddr=0, Count cleared, FETCH1.
- Adv at RomAddr==LAST:
  - Wrap=1: address -> 0.
  - Wrap=0: address unchanged, Overrun set. Overrun is cleared only by reset or Start.
- Start edge outside IDLE/HALT: ignored. Done/Adv outside EXEC: ignored.
- Edge detect: previous-value registers for Start/Step, reset to 1. A switch held high through reset does not trigger.

## Timing
- Reset (async) values: state IDLE, RomAddr 0, DIN 0, Run 0, Halted 0, Overrun 0, Count 0, edge registers 1.
- Reset asserted mid-EXEC: immediate return to IDLE; pending operand refetch discarded.
- Start edge sampled at edge e:
  - FETCH1 after e.
  - DIN valid after e+2.
  - Run high between e+3 and e+4.
- Done sampled at edge d (free-run):
  - next Run high between d+3 and d+4.
  - Instruction-to-instruction overhead is 3 cycles plus processor latency.
- Adv sampled at edge e:
  - RomAddr new after e.
  - DIN holds new word after e+2.
  - Processor must not consume operand before e+2.
- Run never high for two consecutive cycles. Run never high in PAUSE/HALT/IDLE.
- Count updates on the same edge that accepts Done.

## Test plan
- Reset/Start:
  - Stimulus: Resetn low, then high. Then Start edge with ROM[0]=9'h040.
  - Required: all outputs 0 during reset; DIN=9'h040 after 2 cycles; Run single pulse on cycle 3.
- Free-run halt:
  - Stimulus: LAST=3, Wrap=0, Mode=0; processor model answers Done 2 cycles after Run.
  - Required: RomAddr 0,1,2,3; exactly 4 Run pulses; Halted=1; Count=4.
- Wrap:
  - Stimulus: same setup with Wrap=1.
  - Required: after the 4th Done, RomAddr=0 and the 5th Run shows DIN=ROM[0]; Halted stays 0.
- Single-step:
  - Stimulus: Mode=1; Step held high 5 cycles; no Step for 20 cycles.
  - Required: one instruction per Step edge; State=5 between steps; no Run while idle.
- Operand fetch:
  - Stimulus: ROM[0]=mvi, ROM[1]=9'h1A5; Adv 2 cycles after Run; Done 3 cycles later.
  - Required: DIN=9'h1A5 two cycles after Adv; next fetch from address 2; Count=1.
- Boundary:
  - Stimulus 1: Adv at LAST with Wrap=0. Required: Overrun=1.
  - Stimulus 2: Done and Adv together. Required: only Done effect.
  - Stimulus 3: Resetn pulsed low mid-EXEC. Required: immediate IDLE, RomAddr=0, Count=0.
